// File: rtl/snake_grid_renderer_pkg.sv
// ============================================================================
// snake_pkg: colour constants and shared types for the snake grid renderer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package snake_pkg;

    typedef logic [11:0] rgb444_t;

    localparam rgb444_t HEAD   = 12'h0F0;
    localparam rgb444_t BODY   = 12'h0A0;
    localparam rgb444_t FOOD   = 12'hF00;
    localparam rgb444_t BORDER = 12'h888;
    localparam rgb444_t BG     = 12'h000;

    typedef enum logic [0:0] {
        ST_VISIBLE = 1'b0,
        ST_HIDDEN  = 1'b1
    } blink_state_e;

endpackage

`default_nettype wire

// File: rtl/snake_grid_renderer_if.sv
// ============================================================================
// snake_grid_renderer_if: pixel stream between VGA timing, renderer and DAC.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface snake_grid_renderer_if;
    import snake_pkg::*;

    logic       rdn;
    logic [9:0] col;
    logic [8:0] row;
    rgb444_t    pixel;
    logic       pixel_valid;

    modport master (
        output rdn, col, row,
        input  pixel, pixel_valid
    );

    modport slave (
        input  rdn, col, row,
        output pixel, pixel_valid
    );
endinterface

`default_nettype wire

// File: rtl/snake_grid_renderer_blink_ctrl.sv
// ============================================================================
// snake_blink_ctrl: game-over blink phase, toggled every BLINK_FRAMES ticks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module snake_blink_ctrl
    import snake_pkg::*;
#(
    parameter int BLINK_FRAMES = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    input  logic game_over,
    output logic visible
);
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(BLINK_FRAMES - 1);

    blink_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_VISIBLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // Leaving game-over overrides any tick arriving in the same cycle.
        if (!game_over) begin
            state_d = ST_VISIBLE;
            cnt_d   = '0;
        end else if (frame_tick) begin
            if (cnt_q == C_LAST) begin
                cnt_d   = '0;
                state_d = (state_q == ST_VISIBLE) ? ST_HIDDEN : ST_VISIBLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign visible = (state_q == ST_VISIBLE);

endmodule

`default_nettype wire

// File: rtl/snake_grid_renderer.sv
// ============================================================================
// snake_grid_renderer: 3-stage cell-grid pixel renderer with body RAM lookup.
// Revision: 1.0
// ============================================================================
`default_nettype none

module snake_grid_renderer
    import snake_pkg::*;
#(
    parameter int CELL_LOG2    = 4,
    parameter int GRID_W       = 38,
    parameter int GRID_H       = 28,
    parameter int X0           = 16,
    parameter int Y0           = 16,
    parameter int OUTLINE      = 1,
    parameter int BLINK_FRAMES = 15,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H),
    localparam int AW = $clog2(GRID_W * GRID_H)
) (
    input  logic                  clk,
    input  logic                  rst,
    snake_grid_renderer_if.slave  pix,
    input  logic [XW-1:0]         head_x,
    input  logic [YW-1:0]         head_y,
    input  logic [XW-1:0]         food_x,
    input  logic [YW-1:0]         food_y,
    input  logic                  frame_tick,
    input  logic                  game_over,
    output logic [AW-1:0]         occ_addr,
    input  logic                  occ_rd_data,
    output logic                  visible_o
);
    localparam logic [9:0]    C_X0     = 10'(X0);
    localparam logic [9:0]    C_Y0     = 10'(Y0);
    localparam logic [9:0]    C_XLIM   = 10'(GRID_W << CELL_LOG2);
    localparam logic [9:0]    C_YLIM   = 10'(GRID_H << CELL_LOG2);
    localparam logic [AW-1:0] C_GRID_W = AW'(GRID_W);

    logic          w_visible;
    logic [9:0]    w_dx, w_dy;
    logic [XW-1:0] w_cell_x;
    logic [YW-1:0] w_cell_y;
    logic          w_in_grid, w_outline;
    logic [AW-1:0] occ_addr_d;
    rgb444_t       pixel_d;

    logic [AW-1:0] occ_addr_q;
    logic          valid_q1, in_grid_q1, head_q1, food_q1, outline_q1;
    logic          valid_q2, in_grid_q2, head_q2, food_q2, outline_q2;
    rgb444_t       pixel_q;
    logic          pixel_valid_q;

    snake_blink_ctrl #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .game_over  (game_over),
        .visible    (w_visible)
    );

    // Pixels left of / above the origin wrap to large offsets, so a single
    // unsigned upper-bound compare covers both edges of each axis.
    assign w_dx      = pix.col - C_X0;
    assign w_dy      = {1'b0, pix.row} - C_Y0;
    assign w_in_grid = (w_dx < C_XLIM) && (w_dy < C_YLIM);
    assign w_cell_x  = w_dx[CELL_LOG2 +: XW];
    assign w_cell_y  = w_dy[CELL_LOG2 +: YW];
    assign w_outline = (OUTLINE != 0) &&
                       ((w_dx[CELL_LOG2-1:0] == '0) || (w_dy[CELL_LOG2-1:0] == '0));
    assign occ_addr_d = w_in_grid ? (AW'(w_cell_y) * C_GRID_W + AW'(w_cell_x)) : '0;

    // occ_rd_data answers the address issued one cycle earlier, so it lines
    // up with the stage-2 flags and is consumed directly by the colour mux.
    always_comb begin
        pixel_d = BG;
        if (!valid_q2) begin
            pixel_d = 12'h000;
        end else if (!in_grid_q2) begin
            pixel_d = BORDER;
        end else if (head_q2 && w_visible) begin
            pixel_d = outline_q2 ? BG : HEAD;
        end else if (occ_rd_data && w_visible) begin
            pixel_d = outline_q2 ? BG : BODY;
        end else if (food_q2) begin
            pixel_d = FOOD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_addr_q    <= '0;
            valid_q1      <= 1'b0;
            in_grid_q1    <= 1'b0;
            head_q1       <= 1'b0;
            food_q1       <= 1'b0;
            outline_q1    <= 1'b0;
            valid_q2      <= 1'b0;
            in_grid_q2    <= 1'b0;
            head_q2       <= 1'b0;
            food_q2       <= 1'b0;
            outline_q2    <= 1'b0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
        end else begin
            occ_addr_q    <= occ_addr_d;
            valid_q1      <= ~pix.rdn;
            in_grid_q1    <= w_in_grid;
            head_q1       <= (w_cell_x == head_x) && (w_cell_y == head_y);
            food_q1       <= (w_cell_x == food_x) && (w_cell_y == food_y);
            outline_q1    <= w_outline;
            valid_q2      <= valid_q1;
            in_grid_q2    <= in_grid_q1;
            head_q2       <= head_q1;
            food_q2       <= food_q1;
            outline_q2    <= outline_q1;
            pixel_q       <= pixel_d;
            pixel_valid_q <= valid_q2;
        end
    end

    assign occ_addr        = occ_addr_q;
    assign pix.pixel       = pixel_q;
    assign pix.pixel_valid = pixel_valid_q;
    assign visible_o       = w_visible;

endmodule

`default_nettype wire

// File: tb/tb_snake_grid_renderer.sv
// ============================================================================
// tb_snake_grid_renderer: directed self-checking bench with 1-cycle body RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_snake_grid_renderer;
    import snake_pkg::*;

    logic        clk;
    logic        rst;
    logic [5:0]  head_x, food_x;
    logic [4:0]  head_y, food_y;
    logic        frame_tick, game_over;
    logic [10:0] occ_addr;
    logic        occ_rd_data;
    logic        visible;
    logic        ram [0:1063];

    int n_checks = 0;
    int n_pass   = 0;

    snake_grid_renderer_if pif ();

    snake_grid_renderer dut (
        .clk         (clk),
        .rst         (rst),
        .pix         (pif.slave),
        .head_x      (head_x),
        .head_y      (head_y),
        .food_x      (food_x),
        .food_y      (food_y),
        .frame_tick  (frame_tick),
        .game_over   (game_over),
        .occ_addr    (occ_addr),
        .occ_rd_data (occ_rd_data),
        .visible_o   (visible)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) occ_rd_data <= ram[occ_addr];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference colour for a visible pixel, straight from the rendering rules.
    function automatic rgb444_t model(input int c, input int r, input bit vis);
        int cx, cy, ox, oy;
        bit ol;
        if (c < 16 || c >= 16 + 38 * 16 || r < 16 || r >= 16 + 28 * 16) return 12'h888;
        cx = (c - 16) / 16;  cy = (r - 16) / 16;
        ox = (c - 16) % 16;  oy = (r - 16) % 16;
        ol = (ox == 0) || (oy == 0);
        if (vis && cx == int'(head_x) && cy == int'(head_y)) return ol ? 12'h000 : 12'h0F0;
        if (vis && ram[cy * 38 + cx]) return ol ? 12'h000 : 12'h0A0;
        if (cx == int'(food_x) && cy == int'(food_y)) return 12'hF00;
        return 12'h000;
    endfunction

    task automatic do_pixel(input int c, input int r, input logic rd,
                            output logic [10:0] a, output rgb444_t p, output logic v);
        @(negedge clk);
        pif.rdn = rd; pif.col = 10'(c); pif.row = 9'(r);
        @(negedge clk);
        a = occ_addr;
        pif.rdn = 1'b1; pif.col = '0; pif.row = '0;
        @(negedge clk);
        @(negedge clk);
        p = pif.pixel; v = pif.pixel_valid;
    endtask

    task automatic tick();
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pif.rdn = 1'b0; pif.col = 10'd99; pif.row = 9'd51;
        repeat (4) @(negedge clk);
        n_checks++;
        if (pif.pixel !== 12'h000) $display("FAIL reset_pixel: got %h want 000", pif.pixel);
        else n_pass++;
        n_checks++;
        if (pif.pixel_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", pif.pixel_valid);
        else n_pass++;
        n_checks++;
        if (occ_addr !== 11'd0) $display("FAIL reset_addr: got %0d want 0", occ_addr);
        else n_pass++;
        n_checks++;
        if (visible !== 1'b1) $display("FAIL reset_visible: got %b want 1", visible);
        else n_pass++;
        pif.rdn = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_body();
        logic [10:0] a; rgb444_t p; logic v;
        do_pixel(115, 51, 1'b0, a, p, v);
        n_checks++;
        if (a !== 11'd82) $display("FAIL body_addr: got %0d want 82", a); else n_pass++;
        n_checks++;
        if (p !== 12'h0A0) $display("FAIL body_pixel: got %h want 0A0", p); else n_pass++;
        n_checks++;
        if (v !== 1'b1) $display("FAIL body_valid: got %b want 1", v); else n_pass++;
    endtask

    task automatic test_head_outline();
        logic [10:0] a; rgb444_t p; logic v;
        do_pixel(99, 51, 1'b0, a, p, v);
        n_checks++;
        if (a !== 11'd81) $display("FAIL head_addr: got %0d want 81", a); else n_pass++;
        n_checks++;
        if (p !== 12'h0F0) $display("FAIL head_pixel: got %h want 0F0", p); else n_pass++;
        do_pixel(96, 51, 1'b0, a, p, v);
        n_checks++;
        if (p !== 12'h000) $display("FAIL head_outline_col: got %h want 000", p); else n_pass++;
        // Row 48 is the first pixel row of cell row 2.
        do_pixel(99, 48, 1'b0, a, p, v);
        n_checks++;
        if (p !== 12'h000) $display("FAIL head_outline_row: got %h want 000", p); else n_pass++;
        do_pixel(112, 55, 1'b0, a, p, v);
        n_checks++;
        if (p !== 12'h000) $display("FAIL body_outline: got %h want 000", p); else n_pass++;
    endtask

    task automatic test_food();
        logic [10:0] a; rgb444_t p; logic v;
        do_pixel(131, 67, 1'b0, a, p, v);
        n_checks++;
        if (p !== 12'hF00) $display("FAIL food_pixel: got %h want F00", p); else n_pass++;
        do_pixel(128, 64, 1'b0, a, p, v);
        n_checks++;
        if (p !== 12'hF00) $display("FAIL food_no_outline: got %h want F00", p); else n_pass++;
    endtask

    task automatic test_border_blank();
        logic [10:0] a; rgb444_t p; logic v;
        do_pixel(5, 100, 1'b0, a, p, v);
        n_checks++;
        if (p !== 12'h888) $display("FAIL border_pixel: got %h want 888", p); else n_pass++;
        n_checks++;
        if (a !== 11'd0) $display("FAIL border_addr: got %0d want 0", a); else n_pass++;
        do_pixel(624, 51, 1'b0, a, p, v);
        n_checks++;
        if (p !== 12'h888) $display("FAIL border_right: got %h want 888", p); else n_pass++;
        do_pixel(100, 464, 1'b0, a, p, v);
        n_checks++;
        if (p !== 12'h888) $display("FAIL border_bottom: got %h want 888", p); else n_pass++;
        do_pixel(15, 51, 1'b0, a, p, v);
        n_checks++;
        if (p !== 12'h888) $display("FAIL border_left: got %h want 888", p); else n_pass++;
        do_pixel(623, 463, 1'b0, a, p, v);
        n_checks++;
        if (a !== 11'd1063) $display("FAIL last_cell_addr: got %0d want 1063", a); else n_pass++;
        n_checks++;
        if (p !== 12'h000) $display("FAIL last_cell_pixel: got %h want 000", p); else n_pass++;
        do_pixel(99, 51, 1'b1, a, p, v);
        n_checks++;
        if (p !== 12'h000) $display("FAIL blank_pixel: got %h want 000", p); else n_pass++;
        n_checks++;
        if (v !== 1'b0) $display("FAIL blank_valid: got %b want 0", v); else n_pass++;
    endtask

    task automatic test_blink();
        logic [10:0] a; rgb444_t p; logic v;
        game_over = 1'b1;
        repeat (14) tick();
        do_pixel(99, 51, 1'b0, a, p, v);
        n_checks++;
        if (p !== 12'h0F0) $display("FAIL blink_14_head: got %h want 0F0", p); else n_pass++;
        tick();
        do_pixel(99, 51, 1'b0, a, p, v);
        n_checks++;
        if (p !== 12'h000) $display("FAIL blink_hidden_head: got %h want 000", p); else n_pass++;
        do_pixel(115, 51, 1'b0, a, p, v);
        n_checks++;
        if (p !== 12'h000) $display("FAIL blink_hidden_body: got %h want 000", p); else n_pass++;
        do_pixel(131, 67, 1'b0, a, p, v);
        n_checks++;
        if (p !== 12'hF00) $display("FAIL blink_hidden_food: got %h want F00", p); else n_pass++;
        repeat (15) tick();
        do_pixel(99, 51, 1'b0, a, p, v);
        n_checks++;
        if (p !== 12'h0F0) $display("FAIL blink_restored_head: got %h want 0F0", p); else n_pass++;
        repeat (15) tick();
        do_pixel(99, 51, 1'b0, a, p, v);
        n_checks++;
        if (p !== 12'h000) $display("FAIL blink_hidden_again: got %h want 000", p); else n_pass++;
        @(negedge clk); frame_tick = 1'b1; game_over = 1'b0;
        @(negedge clk); frame_tick = 1'b0;
        n_checks++;
        if (visible !== 1'b1) $display("FAIL blink_drop_visible: got %b want 1", visible); else n_pass++;
        do_pixel(99, 51, 1'b0, a, p, v);
        n_checks++;
        if (p !== 12'h0F0) $display("FAIL blink_drop_head: got %h want 0F0", p); else n_pass++;
        game_over = 1'b1;
        repeat (14) tick();
        do_pixel(99, 51, 1'b0, a, p, v);
        n_checks++;
        if (p !== 12'h0F0) $display("FAIL blink_counter_cleared: got %h want 0F0", p); else n_pass++;
        game_over = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        localparam int N = 31;
        localparam int RST_AT = 15;
        rgb444_t exp_pix [0:N+2];
        logic    exp_val [0:N+2];
        bit      rst_at  [0:N+2];
        rgb444_t want_p;
        logic    want_v;
        bit      killed;
        for (int j = 0; j < N + 3; j++) begin
            @(negedge clk);
            if (j >= 3) begin
                killed = rst_at[j-3] || rst_at[j-2] || rst_at[j-1];
                want_p = killed ? 12'h000 : exp_pix[j-3];
                want_v = killed ? 1'b0    : exp_val[j-3];
                n_checks++;
                if (pif.pixel !== want_p || pif.pixel_valid !== want_v)
                    $display("FAIL sweep_%0d: got %h/%b want %h/%b",
                             j - 3, pif.pixel, pif.pixel_valid, want_p, want_v);
                else n_pass++;
            end
            rst_at[j] = (j == RST_AT);
            rst       = (j == RST_AT);
            if (j < N) begin
                pif.rdn = 1'b0; pif.col = 10'(90 + j); pif.row = 9'd51;
                exp_pix[j] = model(90 + j, 51, 1'b1);
                exp_val[j] = 1'b1;
            end else begin
                pif.rdn = 1'b1; pif.col = '0; pif.row = '0;
                exp_pix[j] = 12'h000;
                exp_val[j] = 1'b0;
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pif.rdn = 1'b1; pif.col = '0; pif.row = '0;
        head_x = 6'd5; head_y = 5'd2;
        food_x = 6'd7; food_y = 5'd3;
        frame_tick = 1'b0; game_over = 1'b0;
        for (int i = 0; i < 1064; i++) ram[i] = 1'b0;
        ram[81] = 1'b1;
        ram[82] = 1'b1;

        test_reset();
        test_body();
        test_head_outline();
        test_food();
        test_border_blank();
        test_blink();
        test_back_to_back();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
